sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer in front of sram_model.
//  Accepts valid/ready commands from port A (fetch side) and port B (load/store side).
//  Registers the granted command onto the SRAM pins and returns read data/write
//  acknowledge to the owning port. Fully pipelined: one access per cycle, fixed 2-cycle latency.
// PARAMETERS
//  AW   8   SRAM word-address width (matches sram_model io_adr)
//  DW   32  data width (matches io_d/io_q)
//  SW   4   strobe width, DW/8
// PORTS
//  clock          in   1   sole clock, rising edge
//  reset          in   1   asynchronous, active-low reset
//  a_req_valid    in   1   port A command valid
//  a_req_ready    out  1   port A command accepted this cycle (valid&ready = handshake)
//  a_req_adr      in   AW  port A word address
//  a_req_wen      in   1   1=write, 0=read
//  a_req_wstrb    in   SW  byte strobes (writes only)
//  a_req_wdata    in   DW  write data
//  a_resp_valid   out  1   port A response; single-cycle pulse, no backpressure
//  a_resp_rdata   out  DW  read data (undefined for write responses)
//  b_*            --   --  identical set for port B
//  io_adr         out  AW  to sram_model
//  io_cen         out  1   SRAM access enable, 1=access this cycle
//  io_wen         out  1   SRAM write, 1=write
//  io_wstrb       out  SW  SRAM byte strobes
//  io_d           out  DW  SRAM write data
//  io_q           in   DW  SRAM read data, valid the cycle after io_cen=1
// BEHAVIOUR
//  Reset (reset=0, async): io_cen/io_wen/io_wstrb/io_adr/io_d=0, *_resp_valid=0,
//   prio=A, response tag pipe cleared. Ready outputs are 0 while reset is asserted.
//  Arbitration is combinational in cycle T:
//   - Only A valid -> a_req_ready=1; only B valid -> b_req_ready=1.
//   - Both valid -> grant the port held in prio; the other port's ready=0.
//   - Neither valid -> no grant, prio unchanged.
//   - Ready never depends on its own valid being high except through the contention rule.
//  prio update on any grant: prio <= the non-granted port. Strict alternation under
//   contention; no starvation (worst-case wait 1 cycle).
//  Command stage (T+1): registered io_cen=1, io_adr/io_wen/io_wstrb/io_d = granted command.
//   Without a grant, io_cen=0 and the other io_* hold their last values.
//   Read commands drive io_wstrb=0 and io_d=0.
//  Tag pipe: valid bit and owner bit registered alongside the command (T+1), then again (T+2).
//  Response stage (T+2): owner's *_resp_valid=1 for exactly one cycle.
//   *_resp_rdata = io_q (combinational pass-through; both ports see io_q, only owner's valid is high).
//   Writes also get a response (ack), rdata don't-care.
//  Latency: handshake in T -> resp_valid in T+2, for every access. Throughput: 1 access/cycle total.
//  Ordering: responses per port are returned in acceptance order. The two ports never
//   receive a response in the same cycle.
//  Write-then-read, same address, back-to-back (T, T+1): the read returns the new data
//   (SRAM sequential order; no forwarding needed).
//  Reset mid-operation: in-flight tags are discarded. No resp_valid is produced for
//   commands accepted before reset. prio returns to A.
//  Address wrap: no arithmetic on addresses; AW bits pass through unchanged.
// STRUCTURE
//  Shared package sram_pkg: AW/DW/SW defaults, owner encoding (OWN_A=0, OWN_B=1),
//   and a command struct {adr, wen, wstrb, wdata}.
//  One natural sub-module: rr_arb2 (2-way round-robin grant + prio flop).
//   Command register and tag pipe stay in sram_arbiter.
// TESTING
//  1. Hold reset=0, toggle all inputs -> io_cen=0, resp_valid=0, readys=0.
//     Release reset -> first grant goes to A.
//  2. A: write adr=0x10, wstrb=4'hF, wdata=0xDEADBEEF; next cycle A read 0x10
//     -> a_resp_valid at T+2 (ack) and T+3 with rdata=0xDEADBEEF.
//  3. A and B both valid for 4 cycles -> grants A,B,A,B.
//     Responses alternate a/b starting at T+2; b_resp_valid never coincides with a_resp_valid.
//  4. Write 0x20 = 0x11223344, then write wstrb=4'b0101 data 0xAABBCCDD, then read
//     -> rdata=0x11BB33DD.
//  5. Only B valid for 3 cycles, then both valid -> B granted 3 times, then A first
//     (prio=A after B grants).
//  6. Accept reads at T and T+1, assert reset at T+1 for 1 cycle -> no resp_valid at T+2/T+3;
//     after release, a new A read returns correct data at +2.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: default widths, owner encoding and command layout.
package sram_pkg;

  localparam int unsigned SRAM_AW = 8;
  localparam int unsigned SRAM_DW = 32;
  localparam int unsigned SRAM_SW = SRAM_DW / 8;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  typedef struct packed {
    logic [SRAM_AW-1:0] adr;
    logic               wen;
    logic [SRAM_SW-1:0] wstrb;
    logic [SRAM_DW-1:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational ready/grant plus the priority flop.
module rr_arb2
  import sram_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_a,
  input  logic i_req_b,
  output logic o_rdy_a,
  output logic o_rdy_b,
  output logic o_gnt_a,
  output logic o_gnt_b
);

  owner_e r_prio;
  owner_e w_prio_next;

  // A port's ready only looks at the other port's request, never at its own.
  always_comb begin
    o_rdy_a     = i_rst_n & (~i_req_b | (r_prio == OWN_A));
    o_rdy_b     = i_rst_n & (~i_req_a | (r_prio == OWN_B));
    o_gnt_a     = i_req_a & o_rdy_a;
    o_gnt_b     = i_req_b & o_rdy_b;
    w_prio_next = r_prio;
    if (o_gnt_a) begin
      w_prio_next = OWN_B;
    end else if (o_gnt_b) begin
      w_prio_next = OWN_A;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prio <= OWN_A;
    end else begin
      r_prio <= w_prio_next;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter and two-stage sequencer between two requesters and a synchronous SRAM.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned AW = SRAM_AW,
  parameter int unsigned DW = SRAM_DW,
  parameter int unsigned SW = DW / 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          a_req_valid,
  output logic          a_req_ready,
  input  logic [AW-1:0] a_req_adr,
  input  logic          a_req_wen,
  input  logic [SW-1:0] a_req_wstrb,
  input  logic [DW-1:0] a_req_wdata,
  output logic          a_resp_valid,
  output logic [DW-1:0] a_resp_rdata,
  input  logic          b_req_valid,
  output logic          b_req_ready,
  input  logic [AW-1:0] b_req_adr,
  input  logic          b_req_wen,
  input  logic [SW-1:0] b_req_wstrb,
  input  logic [DW-1:0] b_req_wdata,
  output logic          b_resp_valid,
  output logic [DW-1:0] b_resp_rdata,
  output logic [AW-1:0] io_adr,
  output logic          io_cen,
  output logic          io_wen,
  output logic [SW-1:0] io_wstrb,
  output logic [DW-1:0] io_d,
  input  logic [DW-1:0] io_q
);

  typedef struct packed {
    logic [AW-1:0] adr;
    logic          wen;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic   w_gnt_a;
  logic   w_gnt_b;
  logic   w_gnt;
  cmd_t   w_cmd;
  cmd_t   r_cmd;
  logic   r_cen;
  owner_e r_own1;
  logic   r_v2;
  owner_e r_own2;

  rr_arb2 u_arb (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_req_a (a_req_valid),
    .i_req_b (b_req_valid),
    .o_rdy_a (a_req_ready),
    .o_rdy_b (b_req_ready),
    .o_gnt_a (w_gnt_a),
    .o_gnt_b (w_gnt_b)
  );

  assign w_gnt = w_gnt_a | w_gnt_b;

  // Reads carry zero strobes and data so the SRAM pins stay clean.
  always_comb begin
    w_cmd = '0;
    if (w_gnt_b) begin
      w_cmd.adr   = b_req_adr;
      w_cmd.wen   = b_req_wen;
      w_cmd.wstrb = b_req_wen ? b_req_wstrb : '0;
      w_cmd.wdata = b_req_wen ? b_req_wdata : '0;
    end else begin
      w_cmd.adr   = a_req_adr;
      w_cmd.wen   = a_req_wen;
      w_cmd.wstrb = a_req_wen ? a_req_wstrb : '0;
      w_cmd.wdata = a_req_wen ? a_req_wdata : '0;
    end
  end

  // r_cen doubles as the stage-1 tag valid bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmd  <= '0;
      r_cen  <= 1'b0;
      r_own1 <= OWN_A;
      r_v2   <= 1'b0;
      r_own2 <= OWN_A;
    end else begin
      r_cen <= w_gnt;
      if (w_gnt) begin
        r_cmd <= w_cmd;
      end
      r_own1 <= w_gnt_b ? OWN_B : OWN_A;
      r_v2   <= r_cen;
      r_own2 <= r_own1;
    end
  end

  assign io_adr   = r_cmd.adr;
  assign io_cen   = r_cen;
  assign io_wen   = r_cmd.wen;
  assign io_wstrb = r_cmd.wstrb;
  assign io_d     = r_cmd.wdata;

  assign a_resp_valid = r_v2 & (r_own2 == OWN_A);
  assign b_resp_valid = r_v2 & (r_own2 == OWN_B);
  assign a_resp_rdata = io_q;
  assign b_resp_rdata = io_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural byte-strobed SRAM attached.
module tb_sram_arbiter;

  logic        clock;
  logic        reset;
  logic        a_req_valid, a_req_ready, a_req_wen, a_resp_valid;
  logic [7:0]  a_req_adr;
  logic [3:0]  a_req_wstrb;
  logic [31:0] a_req_wdata, a_resp_rdata;
  logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid;
  logic [7:0]  b_req_adr;
  logic [3:0]  b_req_wstrb;
  logic [31:0] b_req_wdata, b_resp_rdata;
  logic [7:0]  io_adr;
  logic        io_cen, io_wen;
  logic [3:0]  io_wstrb;
  logic [31:0] io_d, io_q;

  int n_checks = 0;
  int n_errors = 0;

  sram_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .a_req_valid  (a_req_valid),
    .a_req_ready  (a_req_ready),
    .a_req_adr    (a_req_adr),
    .a_req_wen    (a_req_wen),
    .a_req_wstrb  (a_req_wstrb),
    .a_req_wdata  (a_req_wdata),
    .a_resp_valid (a_resp_valid),
    .a_resp_rdata (a_resp_rdata),
    .b_req_valid  (b_req_valid),
    .b_req_ready  (b_req_ready),
    .b_req_adr    (b_req_adr),
    .b_req_wen    (b_req_wen),
    .b_req_wstrb  (b_req_wstrb),
    .b_req_wdata  (b_req_wdata),
    .b_resp_valid (b_resp_valid),
    .b_resp_rdata (b_resp_rdata),
    .io_adr       (io_adr),
    .io_cen       (io_cen),
    .io_wen       (io_wen),
    .io_wstrb     (io_wstrb),
    .io_d         (io_d),
    .io_q         (io_q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous SRAM: read data appears the cycle after io_cen.
  logic [31:0] mem [0:255];
  initial io_q = '0;
  always @(posedge clock) begin
    if (io_cen) begin
      if (io_wen) begin
        for (int k = 0; k < 4; k++) begin
          if (io_wstrb[k]) mem[io_adr][8*k +: 8] <= io_d[8*k +: 8];
        end
      end else begin
        io_q <= mem[io_adr];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic w, input logic [7:0] adr, input logic [3:0] s,
                       input logic [31:0] d);
    a_req_valid = v; a_req_wen = w; a_req_adr = adr; a_req_wstrb = s; a_req_wdata = d;
  endtask

  task automatic drv_b(input logic v, input logic w, input logic [7:0] adr, input logic [3:0] s,
                       input logic [31:0] d);
    b_req_valid = v; b_req_wen = w; b_req_adr = adr; b_req_wstrb = s; b_req_wdata = d;
  endtask

  initial begin
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    reset = 1'b1;
    #2 reset = 1'b0;

    // Step 1: inputs toggling under reset
    for (int i = 0; i < 3; i++) begin
      drv_a(1, i[0], 8'(i + 1), 4'hF, 32'(i + 7));
      drv_b(1, ~i[0], 8'(i + 9), 4'hA, 32'(i + 3));
      #1;
      check("rst_a_ready", a_req_ready, 0);
      check("rst_b_ready", b_req_ready, 0);
      tick();
      check("rst_io_cen", io_cen, 0);
      check("rst_io_adr", io_adr, 0);
      check("rst_io_d", io_d, 0);
      check("rst_io_wstrb", io_wstrb, 0);
      check("rst_io_wen", io_wen, 0);
      check("rst_a_resp", a_resp_valid, 0);
      check("rst_b_resp", b_resp_valid, 0);
    end
    reset = 1'b1;
    #1;
    check("first_gnt_a", a_req_ready, 1);
    check("first_gnt_b", b_req_ready, 0);
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    tick();
    check("no_hs_cen", io_cen, 0);

    // Step 2: write then back-to-back read on A
    drv_a(1, 1, 8'h10, 4'hF, 32'hDEADBEEF);
    #1 check("s2_a_ready0", a_req_ready, 1);
    tick();
    check("s2_cen", io_cen, 1);
    check("s2_wen", io_wen, 1);
    check("s2_adr", io_adr, 8'h10);
    check("s2_d", io_d, 32'hDEADBEEF);
    check("s2_wstrb", io_wstrb, 4'hF);
    drv_a(1, 0, 8'h10, 4'hF, 32'hFFFF0000);
    #1 check("s2_a_ready1", a_req_ready, 1);
    tick();
    check("s2_ack", a_resp_valid, 1);
    check("s2_ack_b", b_resp_valid, 0);
    check("s2_rd_wen", io_wen, 0);
    check("s2_rd_wstrb", io_wstrb, 0);
    check("s2_rd_d", io_d, 0);
    drv_a(0, 0, 0, 0, 0);
    tick();
    check("s2_rd_valid", a_resp_valid, 1);
    check("s2_rd_data", a_resp_rdata, 32'hDEADBEEF);
    tick();
    check("s2_idle_resp", a_resp_valid, 0);
    check("s2_idle_cen", io_cen, 0);
    check("s2_hold_adr", io_adr, 8'h10);

    // One B write brings prio back to A
    drv_b(1, 1, 8'h40, 4'hF, 32'h40404040);
    #1 check("b_only_ready", b_req_ready, 1);
    tick();
    drv_b(0, 0, 0, 0, 0);
    tick();
    check("b_ack", b_resp_valid, 1);
    check("b_ack_a", a_resp_valid, 0);
    tick();

    // Step 3: contention, grants A,B,A,B
    drv_a(1, 1, 8'h50, 4'hF, 32'hA0A0A0A0);
    drv_b(1, 1, 8'h60, 4'hF, 32'hB0B0B0B0);
    #1;
    check("s3_d0_ra", a_req_ready, 1);
    check("s3_d0_rb", b_req_ready, 0);
    tick();
    check("s3_d1_adr", io_adr, 8'h50);
    drv_a(1, 0, 8'h50, 4'h0, 32'h0);
    #1;
    check("s3_d1_ra", a_req_ready, 0);
    check("s3_d1_rb", b_req_ready, 1);
    tick();
    check("s3_d2_adr", io_adr, 8'h60);
    check("s3_d2_a_resp", a_resp_valid, 1);
    check("s3_d2_b_resp", b_resp_valid, 0);
    drv_b(1, 0, 8'h60, 4'h0, 32'h0);
    #1;
    check("s3_d2_ra", a_req_ready, 1);
    check("s3_d2_rb", b_req_ready, 0);
    tick();
    check("s3_d3_adr", io_adr, 8'h50);
    check("s3_d3_wen", io_wen, 0);
    check("s3_d3_a_resp", a_resp_valid, 0);
    check("s3_d3_b_resp", b_resp_valid, 1);
    drv_a(1, 0, 8'h10, 4'h0, 32'h0);
    #1;
    check("s3_d3_ra", a_req_ready, 0);
    check("s3_d3_rb", b_req_ready, 1);
    tick();
    check("s3_d4_adr", io_adr, 8'h60);
    check("s3_d4_a_resp", a_resp_valid, 1);
    check("s3_d4_b_resp", b_resp_valid, 0);
    check("s3_d4_rdata", a_resp_rdata, 32'hA0A0A0A0);
    drv_b(0, 0, 0, 0, 0);
    #1 check("s3_d4_ra", a_req_ready, 1);
    tick();
    check("s3_d5_adr", io_adr, 8'h10);
    check("s3_d5_a_resp", a_resp_valid, 0);
    check("s3_d5_b_resp", b_resp_valid, 1);
    check("s3_d5_rdata", b_resp_rdata, 32'hB0B0B0B0);
    drv_a(0, 0, 0, 0, 0);
    tick();
    check("s3_d6_a_resp", a_resp_valid, 1);
    check("s3_d6_b_resp", b_resp_valid, 0);
    check("s3_d6_rdata", a_resp_rdata, 32'hDEADBEEF);
    tick();

    // Step 4: partial-strobe overwrite
    drv_a(1, 1, 8'h20, 4'hF, 32'h11223344);
    tick();
    drv_a(1, 1, 8'h20, 4'b0101, 32'hAABBCCDD);
    tick();
    check("s4_wstrb", io_wstrb, 4'b0101);
    check("s4_d", io_d, 32'hAABBCCDD);
    check("s4_ack0", a_resp_valid, 1);
    drv_a(1, 0, 8'h20, 4'hF, 32'h0);
    tick();
    check("s4_rd_wstrb", io_wstrb, 4'h0);
    check("s4_ack1", a_resp_valid, 1);
    drv_a(0, 0, 0, 0, 0);
    tick();
    check("s4_rd_valid", a_resp_valid, 1);
    check("s4_rd_data", a_resp_rdata, 32'h11BB33DD);
    tick();

    // Step 5: B alone three times, then contention goes to A
    drv_b(1, 1, 8'h70, 4'hF, 32'h00000001);
    #1 check("s5_f0_rb", b_req_ready, 1);
    tick();
    drv_b(1, 0, 8'h70, 4'h0, 32'h0);
    #1 check("s5_f1_rb", b_req_ready, 1);
    tick();
    drv_b(1, 0, 8'h20, 4'h0, 32'h0);
    #1 check("s5_f2_rb", b_req_ready, 1);
    tick();
    check("s5_f3_b_resp", b_resp_valid, 1);
    check("s5_f3_rdata", b_resp_rdata, 32'h00000001);
    drv_a(1, 0, 8'h70, 4'h0, 32'h0);
    drv_b(1, 1, 8'h74, 4'hF, 32'h77777777);
    #1;
    check("s5_f3_ra", a_req_ready, 1);
    check("s5_f3_rb", b_req_ready, 0);
    tick();
    check("s5_f4_adr", io_adr, 8'h70);
    check("s5_f4_b_resp", b_resp_valid, 1);
    check("s5_f4_rdata", b_resp_rdata, 32'h11BB33DD);
    drv_a(0, 0, 0, 0, 0);
    #1 check("s5_f4_rb", b_req_ready, 1);
    tick();
    check("s5_f5_adr", io_adr, 8'h74);
    check("s5_f5_a_resp", a_resp_valid, 1);
    check("s5_f5_b_resp", b_resp_valid, 0);
    check("s5_f5_rdata", a_resp_rdata, 32'h00000001);
    drv_b(0, 0, 0, 0, 0);
    tick();
    check("s5_f6_b_resp", b_resp_valid, 1);
    check("s5_f6_a_resp", a_resp_valid, 0);
    tick();

    // Step 6: reset with reads in flight; A grant leaves prio=B before reset
    drv_a(1, 0, 8'h10, 4'h0, 32'h0);
    tick();
    drv_a(1, 0, 8'h20, 4'h0, 32'h0);
    reset = 1'b0;
    #1;
    check("s6_rst_ra", a_req_ready, 0);
    check("s6_rst_cen", io_cen, 0);
    tick();
    reset = 1'b1;
    drv_a(0, 0, 0, 0, 0);
    check("s6_g2_a_resp", a_resp_valid, 0);
    check("s6_g2_b_resp", b_resp_valid, 0);
    tick();
    check("s6_g3_a_resp", a_resp_valid, 0);
    check("s6_g3_cen", io_cen, 0);
    drv_a(1, 0, 8'h10, 4'h0, 32'h0);
    drv_b(1, 0, 8'h20, 4'h0, 32'h0);
    #1;
    check("s6_prio_ra", a_req_ready, 1);
    check("s6_prio_rb", b_req_ready, 0);
    tick();
    drv_a(0, 0, 0, 0, 0);
    drv_b(0, 0, 0, 0, 0);
    tick();
    check("s6_new_valid", a_resp_valid, 1);
    check("s6_new_b", b_resp_valid, 0);
    check("s6_new_rdata", a_resp_rdata, 32'hDEADBEEF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
